// File: rtl/env_vca_pkg.sv
// Shared types and constants for the envelope-driven VCA and its slew limiter.
package env_vca_pkg;

  typedef enum logic {TRACK = 1'b0, DUCK = 1'b1} vca_state_e;

  // Unity gain: 1.0 in the unsigned Q(BITS-1) gain format.
  function automatic int unity(input int bits);
    return 1 << (bits - 1);
  endfunction

  // Half an LSB of the product once it is shifted down by BITS-1.
  function automatic int rnd_const(input int bits);
    return 1 << (bits - 2);
  endfunction

endpackage

// File: rtl/env_vca_slew.sv
// Combinational slew limiter: moves cur toward tgt by at most step.
module slew_limiter
  import env_vca_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic [BITS-1:0] cur,
  input  logic [BITS-1:0] tgt,
  input  logic [BITS+7:0] step,
  output logic [BITS-1:0] next
);

  logic            up;
  logic [BITS-1:0] mag;

  always_comb begin
    up   = (tgt >= cur);
    mag  = up ? (tgt - cur) : (cur - tgt);
    next = tgt;
    // step can exceed BITS; truncation is only taken when step < mag
    if ({8'd0, mag} > step)
      next = up ? (cur + step[BITS-1:0]) : (cur - step[BITS-1:0]);
  end

endmodule

// File: rtl/env_vca.sv
// Envelope VCA: slew-limited gain with retrigger duck, 2-stage rounded multiply.
module env_vca
  import env_vca_pkg::*;
#(
  parameter int BITS       = 16,
  parameter int SLEW_SHIFT = 4,
  parameter int DUCK_STEP  = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            trigger,
  input  logic [BITS-1:0] env_in,
  input  logic [BITS-1:0] audio_in,
  input  logic [7:0]      slew_rate,
  output logic [BITS-1:0] audio_out,
  output logic            out_valid,
  output logic [BITS-1:0] gain
);

  localparam int PW = 2 * BITS + 1;
  localparam logic [BITS-1:0]      UNITY = BITS'(unity(BITS));
  localparam logic [BITS-1:0]      DSTEP = BITS'(DUCK_STEP);
  localparam logic signed [PW-1:0] RND   = PW'(rnd_const(BITS));
  localparam logic signed [PW-1:0] SMAX  = PW'(unity(BITS) - 1);
  localparam logic signed [PW-1:0] SMIN  = -PW'(unity(BITS));

  vca_state_e state_q, state_d;
  logic [BITS-1:0] gain_q, gain_d, tgt, slew_next;
  logic [BITS+7:0] step;
  logic            trig_q, pend_q, pend_d, pend_eff;
  logic [2:1]      vld_pipe;
  logic signed [PW-1:0] p_q, p_d, rsum, rsh;
  logic [BITS-1:0] aout_q, aout_d;

  assign tgt      = (env_in > UNITY) ? UNITY : env_in;
  assign step     = {{BITS{1'b0}}, slew_rate} << SLEW_SHIFT;
  // an edge arriving on the ena cycle itself is honoured, not deferred
  assign pend_eff = pend_q | (trigger & ~trig_q);
  assign pend_d   = ena ? 1'b0 : pend_eff;

  slew_limiter #(.BITS(BITS)) u_slew (
    .cur  (gain_q),
    .tgt  (tgt),
    .step (step),
    .next (slew_next)
  );

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    if (ena) begin
      case (state_q)
        TRACK: begin
          if (pend_eff && gain_q != '0)
            state_d = DUCK;
          else
            gain_d = (slew_rate == 8'd0) ? tgt : slew_next;
        end
        DUCK: begin
          gain_d = (gain_q > DSTEP) ? (gain_q - DSTEP) : '0;
          if (gain_d == '0) state_d = TRACK;
        end
        default: state_d = TRACK;
      endcase
    end
  end

  // gain is zero-extended so the product stays a signed multiply
  assign p_d = $signed({{(BITS+1){audio_in[BITS-1]}}, audio_in})
             * $signed({{(BITS+1){1'b0}}, gain_q});

  always_comb begin
    rsum   = p_q + RND;
    rsh    = rsum >>> (BITS - 1);
    aout_d = rsh[BITS-1:0];
    if (rsh > SMAX)      aout_d = SMAX[BITS-1:0];
    else if (rsh < SMIN) aout_d = SMIN[BITS-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= TRACK;
      gain_q   <= '0;
      trig_q   <= 1'b0;
      pend_q   <= 1'b0;
      vld_pipe <= '0;
      p_q      <= '0;
      aout_q   <= '0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      trig_q   <= trigger;
      pend_q   <= pend_d;
      vld_pipe <= {vld_pipe[1], ena};
      if (ena)         p_q    <= p_d;
      if (vld_pipe[1]) aout_q <= aout_d;
    end
  end

  assign audio_out = aout_q;
  assign out_valid = vld_pipe[2];
  assign gain      = gain_q;

endmodule

// File: tb/tb_env_vca.sv
// Scoreboard bench for env_vca: behavioural gain model plus queued output checks.
module tb_env_vca;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, ena = 1'b0, trigger = 1'b0;
  logic [15:0] env_in = '0, audio_in = '0, audio_out, gain;
  logic [7:0]  slew_rate = '0;
  logic        out_valid;

  int   n_run = 0, n_fail = 0, cyc = 0;
  exp_t sb[$];
  int   mg = 0;
  bit   mduck = 0, mpend = 0;

  env_vca #(.BITS(16), .SLEW_SHIFT(4), .DUCK_STEP(64)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .trigger(trigger), .env_in(env_in),
    .audio_in(audio_in), .slew_rate(slew_rate), .audio_out(audio_out),
    .out_valid(out_valid), .gain(gain)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mout(input logic [15:0] a, input int g);
    longint p, r;
    p = longint'($signed(a)) * longint'(g);
    r = (p + 64'sd16384) >>> 15;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  task automatic model_step();
    int t, st, d;
    t  = (env_in > 16'h8000) ? 32768 : int'(env_in);
    st = int'(slew_rate) * 16;
    if (mduck) begin
      mg = (mg > 64) ? mg - 64 : 0;
      if (mg == 0) mduck = 0;
    end else if (mpend && mg != 0) begin
      mduck = 1;
    end else begin
      d = t - mg;
      if (slew_rate == 0 || (d <= st && -d <= st)) mg = t;
      else mg = (d > 0) ? mg + st : mg - st;
    end
    mpend = 0;
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) chk("unexpected_valid", 32'(out_valid), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("audio_out", 32'(audio_out), 32'(e.data));
        chk("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic drv(input logic [15:0] a);
    @(negedge clk);
    ena = 1'b1;
    audio_in = a;
    sb.push_back('{mout(a, mg), cyc + 2});
    model_step();
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      ena = 1'b0;
    end
  endtask

  task automatic tick(input logic [15:0] a);
    drv(a);
    gap(1);
    chk("gain_model", 32'(gain), 32'(mg));
  endtask

  task automatic trig_pulse();
    @(negedge clk); trigger = 1'b1;
    @(negedge clk); trigger = 1'b0;
    mpend = 1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_gain", 32'(gain), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_audio", 32'(audio_out), 32'd0);
    rst_n = 1'b1;
    gap(2);

    // instant gain, enas with a one-cycle gap
    env_in = 16'h4000;
    tick(16'h2000);
    tick(16'h2000);
    gap(3);

    // slew toward 0x40 in steps of 16, then hold
    env_in = 16'h0000; tick(16'h1234); gap(3);
    slew_rate = 8'd1; env_in = 16'h0040;
    tick(16'h1000); chk("slew1", 32'(gain), 32'd16);
    tick(16'h1000); chk("slew2", 32'(gain), 32'd32);
    tick(16'h1000); chk("slew3", 32'(gain), 32'd48);
    tick(16'h1000); chk("slew4", 32'(gain), 32'd64);
    tick(16'h1000); chk("slew_hold", 32'(gain), 32'd64);
    slew_rate = 8'd0; env_in = 16'h0000;
    tick(16'h1000); chk("slew_zero", 32'(gain), 32'd0);
    gap(3);

    // clamp to unity and full-scale products
    env_in = 16'hFFFF;
    tick(16'h0000); chk("unity", 32'(gain), 32'h8000);
    tick(16'h8000);
    tick(16'h7FFF);
    gap(3);

    // back-to-back enas give back-to-back outputs
    drv(16'h1111); drv(16'hEEEE); drv(16'h7FFF);
    gap(4);

    // rounding at gain 1
    env_in = 16'h0001;
    tick(16'h0000); chk("gain_one", 32'(gain), 32'd1);
    tick(16'h4000);
    tick(16'h3FFF);
    tick(16'hC000);
    gap(3);

    // duck on retrigger, second trigger ignored, then recover
    env_in = 16'h0100;
    tick(16'h0000); chk("duck_start", 32'(gain), 32'h100);
    trig_pulse();
    tick(16'h4000); chk("duck_enter", 32'(gain), 32'h100);
    tick(16'h4000); chk("duck_c0", 32'(gain), 32'hC0);
    trig_pulse();
    tick(16'h4000); chk("duck_80", 32'(gain), 32'h80);
    tick(16'h4000); chk("duck_40", 32'(gain), 32'h40);
    tick(16'h4000); chk("duck_00", 32'(gain), 32'h0);
    tick(16'h4000); chk("duck_recover", 32'(gain), 32'h100);
    gap(3);

    // async reset mid-pipeline with gain 0x3000
    env_in = 16'h3000;
    tick(16'h4000); chk("pre_rst_gain", 32'(gain), 32'h3000);
    tick(16'h4000);
    gap(3);
    @(negedge clk); ena = 1'b1; audio_in = 16'h4000;
    @(posedge clk); #2;
    ena = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_gain", 32'(gain), 32'd0);
    chk("arst_audio", 32'(audio_out), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    mg = 0; mduck = 0; mpend = 0;
    gap(2);
    rst_n = 1'b1;
    gap(5);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/env_vca.md
Name: env_vca

Overview:
- Voice-amplitude stage directly downstream of the envelope generator.
- Takes the stepped unsigned envelope level and slew-limits it into a smooth gain, declicking on retrigger.
- Multiplies the signed audio sample by that gain, with rounding and saturation, in a 2-stage pipeline.
- Output feeds the mixer/DAC path; advances on the sample-rate enable tick.

Parameters:
- BITS, 16: audio, envelope and gain width; matches envelope generator output width.
- SLEW_SHIFT, 4: left shift applied to slew_rate to form the per-sample step.
- DUCK_STEP, 64: per-sample gain decrement while ducking on retrigger.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  sample tick, one-cycle pulse; may be high every cycle.
- trigger  in  1  same trigger that drives the envelope generator; synchronous to clk.
- env_in  in  BITS  unsigned target level from the envelope generator.
- audio_in  in  BITS  signed sample, valid on cycles where ena=1.
- slew_rate  in  8  max gain change per sample = slew_rate<<SLEW_SHIFT; 0 = no slew limit.
- audio_out  out  BITS  signed scaled sample.
- out_valid  out  1  one-cycle pulse marking a new audio_out.
- gain  out  BITS  current gain register, for debug.

Behaviour:
- Reset (async, rst_n=0): gain=0, audio_out=0, out_valid=0, pipeline valid bits=0, state=TRACK. Applies immediately, including mid-duck or mid-pipeline.
- Target clamp: tgt = min(env_in, 2^(BITS-1)); 2^(BITS-1) is unity gain (UNITY).
- Nothing changes on cycles where ena=0, except trigger edge capture and pipeline drain.
- Trigger edge:
  - Rising edge is detected against a registered copy of trigger.
  - It is latched as pending until the next ena and then consumed.
  - A pending edge is cleared by reset.
- FSM states: TRACK, DUCK.
- TRACK, on each ena:
  - If a pending edge exists and gain!=0: go to DUCK. gain is not updated this ena.
  - Otherwise slew toward tgt: step = slew_rate<<SLEW_SHIFT; diff = tgt-gain.
  - If slew_rate==0 or |diff|<=step: gain<=tgt. Else gain<=gain±step, sign of diff.
  - A pending edge with gain==0 is consumed and behaves as a plain TRACK update.
- DUCK, on each ena:
  - gain<=max(gain-DUCK_STEP, 0).
  - When the new gain is 0, go to TRACK.
  - Further trigger edges are consumed and ignored.
- Gain arithmetic:
  - Unsigned BITS wide, never exceeds UNITY.
  - The step uses a BITS+8-bit intermediate, so no wrap for large slew_rate.
- Pipeline:
  - Stage 1, on ena at cycle N: register p = signed(audio_in) * {1'b0, gain}. Use gain before this ena's update, at 2*BITS+1 bits signed. Set v1=1.
  - Stage 2, at N+1 when v1: r = (p + 2^(BITS-2)) >>> (BITS-1), round half up. Saturate to [-2^(BITS-1), 2^(BITS-1)-1]. audio_out<=r, out_valid<=1.
  - out_valid is high exactly at cycle N+2 relative to the ena edge. Latency is 2 cycles.
  - audio_out holds its value between valid pulses.
  - Back-to-back ena gives back-to-back out_valid.

Decomposition:
- Package env_vca_pkg:
  - state enum {TRACK, DUCK};
  - function unity(BITS);
  - rounding-constant function.
- Sub-module slew_limiter:
  - inputs: cur, tgt, step; output: next;
  - combinational, reused later by filter-cutoff smoothing.

Test Plan:
- Reset: rst_n low while gain=0x3000 and v1=1 → gain, audio_out and out_valid are 0 in the same cycle; no out_valid after release.
- Instant gain: slew_rate=0, env_in=0x4000, audio_in=0x2000, two enas 1 cycle apart → first output 0x0000 (old gain 0), second output 0x1000; out_valid at ena+2 each.
- Slew: slew_rate=1 (step 16), env_in=0x0040 from gain 0 → gain 16, 32, 48, 64 over 4 enas, then holds at 64; env_in=0 with slew_rate=0 → 0 on the next ena.
- Unity/clamp:
  - env_in=0xFFFF, slew_rate=0 → gain=0x8000.
  - audio_in=0x8000 → audio_out=0x8000.
  - audio_in=0x7FFF → audio_out=0x7FFF.
- Rounding: gain=1; audio_in=0x4000 → 1; audio_in=0x3FFF → 0; audio_in=0xC000 → 0 (-0.5 rounds up).
- Duck: gain=0x0100, env_in=0x0100, trigger pulse then enas → gain 0xC0, 0x80, 0x40, 0x00; a second trigger during DUCK is ignored; the next ena in TRACK returns gain to 0x0100 with slew_rate=0.
